arrow_scroll_ctrl: RTL

//  Sequences the 16x16 red/green LED matrix for the dance game. Owns a 4-lane playfield of arrows

---
 rtl/ddr_pkg.sv | 21 ++
 rtl/arrow_scroll_ctrl_step_tick_gen.sv | 27 ++
 rtl/arrow_scroll_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared types and geometry for the dance-game LED matrix controller.
package ddr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam int LANES  = 4;
   localparam int LANE_W = 4;
   localparam int ROWS   = 16;

   // Column mask of one lane within a 16-bit matrix row.
   function automatic logic [ROWS-1:0] lane_mask(input logic [1:0] lane);
      logic [ROWS-1:0] base;
      base = ROWS'((1 << LANE_W) - 1);
      return base << (LANE_W * int'(lane));
   endfunction

endpackage

// File: rtl/arrow_scroll_ctrl_step_tick_gen.sv
// Scroll-step divider: one-cycle tick every DIV enabled cycles; count restarts while disabled.
module step_tick_gen #(
   parameter int DIV = 12_500_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(DIV - 1));

   always_ff @(posedge CLK) begin
      if (RST || !en) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/arrow_scroll_ctrl.sv
// Dance-game playfield: 4 scrolling lanes, hit/miss judging, score and 16x16 matrix drive.
// Optional HIT_FLASH_EN: a hit lane's target-row columns flash green until the next step.
module arrow_scroll_ctrl
   import ddr_pkg::*;
#(
   parameter int STEP_DIV   = 12_500_000,
   parameter int TARGET_ROW = 1,
   parameter int MAX_MISS   = 8,
   parameter int SCORE_W    = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 spawn_valid,
   input  logic [1:0]           spawn_lane,
   output logic                 spawn_ready,
   input  logic [3:0]           key,
   output logic [15:0][15:0]    RedPixels,
   output logic [15:0][15:0]    GrnPixels,
   output logic                 hit,
   output logic                 miss,
   output logic [SCORE_W-1:0]   score,
   output logic                 game_over
);

   state_t                      state;
   logic                        start_q;
   logic [LANES-1:0]            key_q;
   logic [LANES-1:0][ROWS-1:0]  lane;
   logic [LANES-1:0]            pending;
   logic [7:0]                  miss_cnt;
   logic                        tick;

   logic                        start_edge;
   logic [LANES-1:0]            press;
   logic [LANES-1:0]            hits;
   logic [LANES-1:0]            miss_lanes;
   logic [LANES-1:0][ROWS-1:0]  lane_judged;
   logic [LANES-1:0][ROWS-1:0]  lane_shift;
   logic [2:0]                  hit_n;
   logic [2:0]                  miss_n;
   logic [SCORE_W:0]            score_sum;
   logic [SCORE_W-1:0]          score_next;
   logic [8:0]                  miss_sum;
   logic [7:0]                  miss_cnt_next;
   logic [15:0][15:0]           red_img;

   step_tick_gen #(.DIV(STEP_DIV)) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .en   (state == RUN),
      .tick (tick)
   );

   assign start_edge = start & ~start_q;
   assign press      = key & ~key_q;

   // Spawn handshake: a transfer happens on any cycle with spawn_valid & spawn_ready.
   // Ready drops on the tick cycle so a spawn never races the pending->row15 move.
   assign spawn_ready = (state == RUN) & ~pending[spawn_lane] & ~tick;

   // Judge presses on the pre-shift image, then shift the judged image.
   always_comb begin
      lane_judged = lane;
      lane_shift  = '0;
      hits        = '0;
      miss_lanes  = '0;
      hit_n       = '0;
      miss_n      = '0;
      for (int l = 0; l < LANES; l++) begin
         hits[l]                   = press[l] & lane[l][TARGET_ROW];
         lane_judged[l][TARGET_ROW] = lane[l][TARGET_ROW] & ~press[l];
         miss_lanes[l]             = lane_judged[l][0];
         lane_shift[l]             = {pending[l], lane_judged[l][ROWS-1:1]};
         hit_n                     = hit_n + 3'(hits[l]);
         miss_n                    = miss_n + 3'(miss_lanes[l]);
      end
   end

   assign score_sum     = {1'b0, score} + (SCORE_W+1)'(hit_n);
   assign score_next    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   assign miss_sum      = {1'b0, miss_cnt} + 9'(miss_n);
   assign miss_cnt_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         key_q     <= '0;
         lane      <= '0;
         pending   <= '0;
         score     <= '0;
         miss_cnt  <= '0;
         hit       <= 1'b0;
         miss      <= 1'b0;
         game_over <= 1'b0;
      end else begin
         start_q <= start;
         key_q   <= key;
         hit     <= 1'b0;
         miss    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state    <= RUN;
                  lane     <= '0;
                  pending  <= '0;
                  score    <= '0;
                  miss_cnt <= '0;
               end
            end
            RUN: begin
               if (|hits) begin
                  hit   <= 1'b1;
                  score <= score_next;
               end
               if (tick) begin
                  lane     <= lane_shift;
                  pending  <= '0;
                  miss     <= |miss_lanes;
                  miss_cnt <= miss_cnt_next;
                  if (miss_cnt_next >= 8'(MAX_MISS)) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                  end
               end else begin
                  lane <= lane_judged;
                  if (spawn_valid && spawn_ready) pending[spawn_lane] <= 1'b1;
               end
            end
            OVER: begin
               if (start_edge) begin
                  state     <= IDLE;
                  game_over <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HIT_FLASH_EN
   logic [LANES-1:0] flash;

   always_ff @(posedge CLK) begin
      if (RST || state != RUN) begin
         flash <= '0;
      end else if (tick) begin
         flash <= hits;
      end else begin
         flash <= flash | hits;
      end
   end
`endif

   always_comb begin
      red_img = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int l = 0; l < LANES; l++) begin
            if (lane[l][r]) red_img[r] = red_img[r] | lane_mask(2'(l));
         end
      end
`ifdef HIT_FLASH_EN
      for (int l = 0; l < LANES; l++) begin
         if (flash[l]) red_img[TARGET_ROW] = red_img[TARGET_ROW] & ~lane_mask(2'(l));
      end
`endif
   end

   // Display follows the registered state by one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         RedPixels <= '0;
         GrnPixels <= '0;
      end else begin
         RedPixels <= '0;
         GrnPixels <= '0;
         case (state)
            IDLE: GrnPixels[TARGET_ROW] <= '1;
            RUN: begin
               RedPixels              <= red_img;
               GrnPixels[TARGET_ROW]  <= '1;
            end
            OVER: RedPixels <= '1;
            default: RedPixels <= '0;
         endcase
      end
   end

endmodule
